ctrl_ramdrv_mc: RTL
===================

# ctrl_ramdrv_mc

Multi-channel dual-port RAM address driver, the parametrised successor of the single-channel ring-buffer/coefficient address driver. It holds per-channel ring-buffer configuration and head pointers for `CH_NUM` interleaved sample streams. For each job it optionally writes one new sample at the advanced head, then streams `len` (data, coefficient) address pairs newest-to-oldest for the MAC datapath. It sits between the controller FSM (start/done handshake) and the sample/coefficient RAM ports.

## Interface
- `ADDR_WIDTH`, 12: RAM address width.
- `TAP_WIDTH`, 8: tap-count width; max taps per channel is 2^TAP_WIDTH-1.
- `CH_NUM`, 4: channel count, ≥1. `CH_W = max(1, clog2(CH_NUM))`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `cfg_we`  in  1  channel configuration write strobe.
- `cfg_ch`  in  CH_W  channel being configured.
- `cfg_base`  in  ADDR_WIDTH  sample segment base pointer.
- `cfg_len`  in  TAP_WIDTH  tap count (ring length).
- `cfg_coef`  in  ADDR_WIDTH  coefficient base pointer.
- `cfg_err`  out  1  1-cycle pulse: config write rejected.
- `start`  in  1  job request, sampled only in IDLE.
- `ch_sel`  in  CH_W  job channel.
- `wr_sample`  in  1  job begins with a sample write.
- `busy`  out  1  job in progress.
- `done`  out  1  1-cycle job completion pulse.
- `data_addr`  out  ADDR_WIDTH  sample RAM address.
- `data_we`  out  1  sample write strobe.
- `coef_addr`  out  ADDR_WIDTH  coefficient RAM address.
- `addr_vld`  out  1  convolution address pair valid.
- `last`  out  1  final pair of the job.

## Operation
- Per channel: `base`, `len`, `coef`, and head offset `h` (0..len-1). All reset to 0.
- A config write sets base/len/coef and clears `h` to 0. A write to the active channel while `busy`, or with `cfg_ch ≥ CH_NUM`, is ignored and pulses `cfg_err`.
- FSM states: IDLE, WRITE, CALC, DONE.
  - IDLE→WRITE: `start & wr_sample`.
  - IDLE→CALC: `start & !wr_sample`.
  - `start` with `ch_sel ≥ CH_NUM`, or with `len == 0`, goes straight to DONE. No address is valid for that job, and no write is issued.
  - WRITE: `h ← (h == len-1) ? 0 : h+1`. Drives `data_addr = base + h_new`, `data_we = 1`. Next state CALC.
  - CALC: tap counter `k` runs 0..len-1. Drives `data_addr = base + ((h − k) mod len)`, `coef_addr = coef + k`, `addr_vld = 1`, and `last = (k == len-1)`. After `last`, next state DONE.
  - DONE: `done = 1` for one cycle, then IDLE.
- Channel, base, len, coef and h are latched at job start. Config writes to other channels during a job take effect immediately.
- Address sums wrap modulo 2^ADDR_WIDTH. The ring index wrap uses compare-and-subtract, not division.
- Ports are driven, never tristated. `data_addr` and `coef_addr` are 0 whenever `addr_vld` and `data_we` are both 0.
- `start` while `busy` is ignored, with no queuing.

## Timing
- Reset values: `busy`, `done`, `data_we`, `addr_vld`, `last`, `cfg_err` = 0; `data_addr` and `coef_addr` = 0; FSM in IDLE.
- Reset asserted mid-job aborts immediately. No `done` is issued, and all channel state clears.
- Outputs are registered. With `start` accepted at edge N:
  - `busy` is high from N+1 through the DONE cycle.
  - With `wr_sample`: WRITE in cycle N+1, first pair in N+2.
  - Without `wr_sample`: first pair in N+1.
- Pairs are issued one per cycle, back-to-back, `len` cycles in total. `done` follows `last` by one cycle.
- A new `start` is accepted in the cycle after `done`, so the minimum job period is len+2 or len+3 cycles.
- `cfg_err` is asserted the cycle after the rejected write.

## Structure
- Shared header `glb_macros.vh` (already present): state encodings `ST_IDLE`/`ST_WRITE`/`ST_CALC`/`ST_DONE` and the `CLOG2` macro.
- Sub-module `ctrl_ramdrv_mc_chtab`: per-channel base/len/coef/h register file. It has a config write port, a head-update port and an asynchronous read port indexed by `ch_sel`.
- The top level holds the FSM, tap counter, ring index arithmetic and output registers.

## Test plan
- Ring wrap: ch1 with base=0x100, len=4, coef=0x800; job with `wr_sample`. Expect a write at 0x101, then pairs (0x101,0x800), (0x100,0x801), (0x103,0x802), (0x102,0x803), `last` on the 4th pair, then `done`.
- Head wrap: 4 write jobs on ch1 (len=4). Expect write addresses 0x101, 0x102, 0x103, 0x100.
- Channel isolation: interleave ch0 (base=0x000, len=3) and ch2 (base=0x200, len=5). Each channel's head advances only on its own jobs, and addresses never cross segments.
- Degenerate cases:
  - len=0: `done` at N+1 with no `addr_vld`.
  - `ch_sel` = CH_NUM when CH_NUM=3: same as len=0.
  - Config write to the busy channel: `cfg_err` pulses and the config is unchanged.
- Handshake/reset: `start` during `busy` is ignored. Assert `rst` low mid-CALC: all outputs 0 asynchronously, no `done`, and after release ch1's head reads 0.
- Address overflow: base=0xFFE, len=4, ADDR_WIDTH=12. Expect addresses 0xFFE, 0xFFF, 0x000, 0x001 in ring order.

Source files
------------

// File: rtl/ctrl_ramdrv_mc_pkg.sv
// Shared FSM encoding and sizing helpers for the multi-channel RAM address driver.
package ctrl_ramdrv_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Channel index width, never narrower than one bit so a single channel still has a select port.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_ramdrv_mc_chtab.sv
// Per-channel ring configuration (base/len/coef) and head offset table.
// Writes land on the next edge; reads are combinational; no backpressure, callers pre-qualify writes.
module ctrl_ramdrv_mc_chtab
    import ctrl_ramdrv_mc_pkg::*;
#(
    parameter int  ADDR_WIDTH = 12,
    parameter int  TAP_WIDTH  = 8,
    parameter int  CH_NUM     = 4,
    localparam int CH_W       = ch_width(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic                  cfg_blk,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [TAP_WIDTH-1:0]  cfg_len,
    input  logic [ADDR_WIDTH-1:0] cfg_coef,
    output logic                  cfg_ok,
    input  logic                  hd_we,
    input  logic [CH_W-1:0]       hd_ch,
    input  logic [TAP_WIDTH-1:0]  hd_val,
    input  logic [CH_W-1:0]       rd_ch,
    output logic                  rd_ok,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic [TAP_WIDTH-1:0]  rd_len,
    output logic [ADDR_WIDTH-1:0] rd_coef,
    output logic [TAP_WIDTH-1:0]  rd_h
);

    logic [ADDR_WIDTH-1:0] base_q [CH_NUM];
    logic [ADDR_WIDTH-1:0] base_d [CH_NUM];
    logic [TAP_WIDTH-1:0]  len_q  [CH_NUM];
    logic [TAP_WIDTH-1:0]  len_d  [CH_NUM];
    logic [ADDR_WIDTH-1:0] coef_q [CH_NUM];
    logic [ADDR_WIDTH-1:0] coef_d [CH_NUM];
    logic [TAP_WIDTH-1:0]  h_q    [CH_NUM];
    logic [TAP_WIDTH-1:0]  h_d    [CH_NUM];

    // Equality decode per channel keeps out-of-range selects harmless for non-power-of-two CH_NUM.
    always_comb begin
        cfg_ok  = 1'b0;
        rd_ok   = 1'b0;
        rd_base = '0;
        rd_len  = '0;
        rd_coef = '0;
        rd_h    = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            base_d[c] = base_q[c];
            len_d[c]  = len_q[c];
            coef_d[c] = coef_q[c];
            h_d[c]    = h_q[c];
            if (cfg_ch == CH_W'(c)) begin
                cfg_ok = 1'b1;
            end
            if (hd_we && (hd_ch == CH_W'(c))) begin
                h_d[c] = hd_val;
            end
            if (cfg_we && !cfg_blk && (cfg_ch == CH_W'(c))) begin
                base_d[c] = cfg_base;
                len_d[c]  = cfg_len;
                coef_d[c] = cfg_coef;
                h_d[c]    = '0;
            end
            if (rd_ch == CH_W'(c)) begin
                rd_ok   = 1'b1;
                rd_base = base_q[c];
                rd_len  = len_q[c];
                rd_coef = coef_q[c];
                rd_h    = h_q[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CH_NUM; c++) begin
                base_q[c] <= '0;
                len_q[c]  <= '0;
                coef_q[c] <= '0;
                h_q[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                base_q[c] <= base_d[c];
                len_q[c]  <= len_d[c];
                coef_q[c] <= coef_d[c];
                h_q[c]    <= h_q[c] == h_d[c] ? h_q[c] : h_d[c];
            end
        end
    end

endmodule

// File: rtl/ctrl_ramdrv_mc.sv
// Multi-channel ring-buffer sample/coefficient address driver: optional head write, then len pairs newest-first.
// Registered outputs, first address one cycle after start; start is ignored while busy, no queuing.
module ctrl_ramdrv_mc
    import ctrl_ramdrv_mc_pkg::*;
#(
    parameter int  ADDR_WIDTH = 12,
    parameter int  TAP_WIDTH  = 8,
    parameter int  CH_NUM     = 4,
    localparam int CH_W       = ch_width(CH_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_we,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [TAP_WIDTH-1:0]  cfg_len,
    input  logic [ADDR_WIDTH-1:0] cfg_coef,
    output logic                  cfg_err,
    input  logic                  start,
    input  logic [CH_W-1:0]       ch_sel,
    input  logic                  wr_sample,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic                  data_we,
    output logic [ADDR_WIDTH-1:0] coef_addr,
    output logic                  addr_vld,
    output logic                  last
);

    localparam logic [TAP_WIDTH-1:0] TAP_ONE = TAP_WIDTH'(1);

    state_t                state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] coef_q, coef_d;
    logic [TAP_WIDTH-1:0]  len_q, len_d;
    logic [TAP_WIDTH-1:0]  h_q, h_d;
    logic [TAP_WIDTH-1:0]  k_q, k_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  data_we_q, data_we_d;
    logic                  addr_vld_q, addr_vld_d;
    logic                  last_q, last_d;
    logic                  cfg_err_q, cfg_err_d;
    logic [ADDR_WIDTH-1:0] data_addr_q, data_addr_d;
    logic [ADDR_WIDTH-1:0] coef_addr_q, coef_addr_d;

    logic                  cfg_ok, cfg_blk, hd_we;
    logic                  rd_ok;
    logic [ADDR_WIDTH-1:0] rd_base, rd_coef;
    logic [TAP_WIDTH-1:0]  rd_len, rd_h;

    function automatic logic [TAP_WIDTH-1:0] head_next(input logic [TAP_WIDTH-1:0] h,
                                                       input logic [TAP_WIDTH-1:0] len);
        return (h == len - TAP_ONE) ? '0 : h + TAP_ONE;
    endfunction

    // (h - k) mod len with h,k < len: bias by len, then at most one subtract.
    function automatic logic [TAP_WIDTH-1:0] ring_idx(input logic [TAP_WIDTH-1:0] h,
                                                      input logic [TAP_WIDTH-1:0] k,
                                                      input logic [TAP_WIDTH-1:0] len);
        logic [TAP_WIDTH:0] s;
        s = {1'b0, h} + {1'b0, len} - {1'b0, k};
        if (s >= {1'b0, len}) begin
            s = s - {1'b0, len};
        end
        return s[TAP_WIDTH-1:0];
    endfunction

    assign cfg_blk = busy_q && (cfg_ch == ch_q);
    assign hd_we   = (state_q == ST_WRITE);

    ctrl_ramdrv_mc_chtab #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .TAP_WIDTH  (TAP_WIDTH),
        .CH_NUM     (CH_NUM)
    ) u_chtab (
        .clk      (clk),
        .rst      (rst),
        .cfg_we   (cfg_we),
        .cfg_blk  (cfg_blk),
        .cfg_ch   (cfg_ch),
        .cfg_base (cfg_base),
        .cfg_len  (cfg_len),
        .cfg_coef (cfg_coef),
        .cfg_ok   (cfg_ok),
        .hd_we    (hd_we),
        .hd_ch    (ch_q),
        .hd_val   (h_q),
        .rd_ch    (ch_sel),
        .rd_ok    (rd_ok),
        .rd_base  (rd_base),
        .rd_len   (rd_len),
        .rd_coef  (rd_coef),
        .rd_h     (rd_h)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus the job context latched at start; h_q holds the advanced head during WRITE.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        base_d  = base_q;
        len_d   = len_q;
        coef_d  = coef_q;
        h_d     = h_q;
        k_d     = k_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ch_d   = ch_sel;
                    base_d = rd_base;
                    len_d  = rd_len;
                    coef_d = rd_coef;
                    h_d    = rd_h;
                    k_d    = '0;
                    if (!rd_ok || (rd_len == '0)) begin
                        state_d = ST_DONE;
                    end else if (wr_sample) begin
                        state_d = ST_WRITE;
                        h_d     = head_next(rd_h, rd_len);
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_WRITE: begin
                state_d = ST_CALC;
                k_d     = '0;
            end
            ST_CALC: begin
                if (k_q == len_q - TAP_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + TAP_ONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        data_we_d   = (state_d == ST_WRITE);
        addr_vld_d  = (state_d == ST_CALC);
        last_d      = addr_vld_d && (k_d == len_d - TAP_ONE);
        data_addr_d = '0;
        coef_addr_d = '0;
        if (data_we_d) begin
            data_addr_d = base_d + ADDR_WIDTH'(h_d);
        end
        if (addr_vld_d) begin
            data_addr_d = base_d + ADDR_WIDTH'(ring_idx(h_d, k_d, len_d));
            coef_addr_d = coef_d + ADDR_WIDTH'(k_d);
        end
        cfg_err_d = cfg_we && (cfg_blk || !cfg_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q        <= '0;
            base_q      <= '0;
            len_q       <= '0;
            coef_q      <= '0;
            h_q         <= '0;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            data_we_q   <= 1'b0;
            addr_vld_q  <= 1'b0;
            last_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            data_addr_q <= '0;
            coef_addr_q <= '0;
        end else begin
            ch_q        <= ch_d;
            base_q      <= base_d;
            len_q       <= len_d;
            coef_q      <= coef_d;
            h_q         <= h_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            data_we_q   <= data_we_d;
            addr_vld_q  <= addr_vld_d;
            last_q      <= last_d;
            cfg_err_q   <= cfg_err_d;
            data_addr_q <= data_addr_d;
            coef_addr_q <= coef_addr_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign data_we   = data_we_q;
    assign addr_vld  = addr_vld_q;
    assign last      = last_q;
    assign cfg_err   = cfg_err_q;
    assign data_addr = data_addr_q;
    assign coef_addr = coef_addr_q;

endmodule
